uart_bus_if: RTL and testbench
==============================

Name: uart_bus_if

Overview:
- Host-side register interface for the `uart` block: the initiator end of its `rd_uart`/`wr_uart` FIFO handshake.
- Decodes a 4-register, 8-bit 65c02-style bus window.
- Drives TX pushes, RX pops and the baud divisor.
- Tracks RX FIFO occupancy to detect overrun; keeps sticky error flags; produces a registered, level-sensitive IRQ.

Parameters:
- FIFO_W, 2, address bits of the attached RX FIFO; occupancy counter range is 0..2**FIFO_W.
- DVSR_RST, 324, reset value of the 21-bit baud divisor (19200 baud at 100 MHz).
- TIMEOUT_CYC, 20000, RX idle-timeout length in clk cycles; used only with UART_IF_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  chip select; qualifies rd_en/wr_en
- addr  in  2  register index
- rd_en  in  1  bus read strobe, one cycle per access
- wr_en  in  1  bus write strobe, one cycle per access
- wr_data  in  8  bus write data
- rd_data  out  8  registered bus read data
- irq  out  1  registered interrupt request, active-high level
- rd_uart  out  1  RX FIFO pop pulse to `uart`
- wr_uart  out  1  TX FIFO push pulse to `uart`
- w_data  out  8  TX byte to `uart`
- dvsr  out  21  baud divisor to `uart`
- r_data  in  8  RX FIFO head from `uart`
- tx_full  in  1  TX FIFO full
- rx_empty  in  1  RX FIFO empty
- rx_done_tick  in  1  one-cycle pulse; `uart` wrote a byte into its RX FIFO

Behaviour:
- Reset values:
  - rd_data=0, irq=0, rd_uart=0, wr_uart=0, w_data=0, dvsr=DVSR_RST.
  - ctrl=0, sticky flags=0, occupancy=0, staging=0.
- Access qualification:
  - rd = cs & rd_en & ~wr_en; wr = cs & wr_en. If both strobes are high, the access is a write only.
  - Reads return data on rd_data one cycle after the strobe. rd_data holds its value otherwise.
- addr 0 DATA, write:
  - If ~tx_full: wr_uart=1 and w_data=wr_data, both registered and visible on the next cycle, one-cycle pulse.
  - If tx_full: no push; set TX_OVF.
- addr 0 DATA, read:
  - If ~rx_empty: rd_data<=r_data and rd_uart=1 for one cycle. Capture and pop share one edge, so the pop is issued one cycle after the strobe with the captured head.
  - If rx_empty: rd_data<=0x00, no pop.
- addr 1 STATUS (read-only):
  - Bit map: [0] ~rx_empty, [1] tx_full, [2] RX_OVR, [3] TX_OVF, [4] RX_TMO (0 if the feature is absent), [6:5]=0, [7] irq.
  - A read returns the pre-clear value, then clears bits 2–4.
  - If a new error event coincides with the clearing read, the event wins and the bit stays set.
- addr 2 CTRL (read/write):
  - Bits: [0] RX_IE, [1] TX_IE, [2] ERR_IE, [5:4] DSEL (divisor byte select), [7:6] reserved, read as 0.
- addr 3 DVSR (read/write):
  - Write, DSEL=0 or 1: loads staging byte 0 or 1.
  - Write, DSEL=2: commits dvsr <= {wr_data[4:0], stage1, stage0} atomically; wr_data[7:5] ignored.
  - Write, DSEL=3: ignored.
  - Read: returns the committed dvsr byte selected by DSEL (bits above 20 read as 0; DSEL=3 returns 0).
- Occupancy counter occ:
  - Updates each cycle: +1 on rx_done_tick, -1 on rd_uart. Both in the same cycle: no change.
  - If rx_done_tick arrives while occ==2**FIFO_W: set RX_OVR and do not increment (the FIFO dropped the byte).
  - Never decrements below 0.
  - occ==0 must agree with rx_empty; this is a checker assertion only.
- irq, registered with one-cycle latency:
  - irq <= (RX_IE & ~rx_empty) | (TX_IE & ~tx_full) | (ERR_IE & (RX_OVR|TX_OVF|RX_TMO)).
- Reset mid-operation: all state returns to reset values on the next edge; any pending push/pop pulse is squashed.

Optional Feature:
- Macro: UART_IF_RX_TIMEOUT_EN.
- With it defined:
  - A counter increments each cycle while ~rx_empty & ~rx_done_tick & ~rd_uart; any of those conditions resets it to 0.
  - Reaching TIMEOUT_CYC-1 sets sticky RX_TMO and holds the counter.
  - RX_TMO feeds STATUS[4] and the ERR_IE term.
- Without it: no counter logic; STATUS[4] reads 0.

Test Plan:
- Reset, then read STATUS and the DVSR bytes -> STATUS=0x00 (given rx_empty=1, tx_full=0); DVSR bytes DSEL=0/1/2 read 0x44/0x01/0x00 (324).
- CTRL=0x00, write DVSR bytes 0x35 and 0x00 via DSEL=0/1, then DSEL=2 with 0xFF -> dvsr=0x1F0035, changing only on the DSEL=2 write edge.
- Write DATA 0xA5 with tx_full=0 -> wr_uart one-cycle pulse with w_data=0xA5. Repeat with tx_full=1 -> no pulse; STATUS reads 0x0A, then reads 0x02.
- Five rx_done_tick pulses with no reads (FIFO_W=2) -> RX_OVR set on the 5th pulse. With CTRL=0x04, irq rises one cycle later.
- rx_empty=0, r_data=0x3C, read DATA in the same cycle as an rx_done_tick -> rd_data=0x3C next cycle, rd_uart pulse, occ unchanged.
- With UART_IF_RX_TIMEOUT_EN and TIMEOUT_CYC=16: one byte pending, idle 16 cycles -> STATUS[4]=1; without the macro, STATUS[4] stays 0.

Source files
------------

// File: rtl/uart_bus_if_if.sv
// Host-side 65c02-style register bus for uart_bus_if: chip select, 2-bit
// register index, one-cycle read/write strobes, write/read data and the IRQ.
interface uart_bus_if_if;
    logic       cs;
    logic [1:0] addr;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       irq;

    modport master (
        output cs, addr, rd_en, wr_en, wr_data,
        input  rd_data, irq
    );

    modport slave (
        input  cs, addr, rd_en, wr_en, wr_data,
        output rd_data, irq
    );
endinterface

// File: rtl/uart_bus_if.sv
// uart_bus_if: host register window (DATA/STATUS/CTRL/DVSR) in front of the
// uart block. Pushes TX bytes, pops RX bytes, holds the baud divisor, tracks
// RX FIFO occupancy for overrun detection and raises a level IRQ.
// Optional macro UART_IF_RX_TIMEOUT_EN adds an RX idle timeout (STATUS[4]).
module uart_bus_if #(
    parameter int          FIFO_W      = 2,
    parameter logic [20:0] DVSR_RST    = 21'd324,
    parameter int          TIMEOUT_CYC = 20000
) (
    input  logic         clk,
    input  logic         reset,
    uart_bus_if_if.slave bus,
    output logic         rd_uart,
    output logic         wr_uart,
    output logic [7:0]   w_data,
    output logic [20:0]  dvsr,
    input  logic [7:0]   r_data,
    input  logic         tx_full,
    input  logic         rx_empty,
    input  logic         rx_done_tick
);
    localparam logic [1:0]      A_DATA    = 2'd0;
    localparam logic [1:0]      A_STAT    = 2'd1;
    localparam logic [1:0]      A_CTRL    = 2'd2;
    localparam logic [7:0]      CTRL_MASK = 8'h37;
    localparam logic [FIFO_W:0] OCC_MAX   = {1'b1, {FIFO_W{1'b0}}};

    logic            rd;
    logic            wr;
    logic [7:0]      ctrl;
    logic [7:0]      stage0;
    logic [7:0]      stage1;
    logic [7:0]      status;
    logic [7:0]      dvsr_byte;
    logic            rx_ovr;
    logic            tx_ovf;
    logic            rx_tmo;
    logic            ovr_evt;
    logic            ovf_evt;
    logic            tmo_evt;
    logic            stat_clr;
    logic [FIFO_W:0] occ;

    // Qualify bus strobes (write wins over read), decode error events and read-mux sources.
    always_comb begin
        rd       = bus.cs & bus.rd_en & ~bus.wr_en;
        wr       = bus.cs & bus.wr_en;
        ovr_evt  = rx_done_tick & (occ == OCC_MAX);
        ovf_evt  = wr & (bus.addr == A_DATA) & tx_full;
        stat_clr = rd & (bus.addr == A_STAT);
        status   = {bus.irq, 2'b00, rx_tmo, tx_ovf, rx_ovr, tx_full, ~rx_empty};
        case (ctrl[5:4])
            2'd0:    dvsr_byte = dvsr[7:0];
            2'd1:    dvsr_byte = dvsr[15:8];
            2'd2:    dvsr_byte = {3'b000, dvsr[20:16]};
            default: dvsr_byte = 8'h00;
        endcase
    end

    // CTRL and divisor staging; the divisor only changes on the DSEL=2 commit write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= 8'h00;
            stage0 <= 8'h00;
            stage1 <= 8'h00;
            dvsr   <= DVSR_RST;
        end else if (wr) begin
            case (bus.addr)
                A_CTRL: ctrl <= bus.wr_data & CTRL_MASK;
                2'd3: begin
                    case (ctrl[5:4])
                        2'd0:    stage0 <= bus.wr_data;
                        2'd1:    stage1 <= bus.wr_data;
                        2'd2:    dvsr   <= {bus.wr_data[4:0], stage1, stage0};
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Registered read data plus the one-cycle TX push / RX pop pulses toward the uart.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data <= 8'h00;
            rd_uart     <= 1'b0;
            wr_uart     <= 1'b0;
            w_data      <= 8'h00;
        end else begin
            rd_uart <= rd & (bus.addr == A_DATA) & ~rx_empty;
            wr_uart <= wr & (bus.addr == A_DATA) & ~tx_full;
            if (wr && (bus.addr == A_DATA) && !tx_full)
                w_data <= bus.wr_data;
            if (rd) begin
                case (bus.addr)
                    A_DATA:  bus.rd_data <= rx_empty ? 8'h00 : r_data;
                    A_STAT:  bus.rd_data <= status;
                    A_CTRL:  bus.rd_data <= ctrl;
                    default: bus.rd_data <= dvsr_byte;
                endcase
            end
        end
    end

    // Sticky error flags: a STATUS read clears them unless a new event lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
            rx_tmo <= 1'b0;
        end else begin
            rx_ovr <= (rx_ovr & ~stat_clr) | ovr_evt;
            tx_ovf <= (tx_ovf & ~stat_clr) | ovf_evt;
            rx_tmo <= (rx_tmo & ~stat_clr) | tmo_evt;
        end
    end

    // RX FIFO occupancy mirror; saturates at full (byte dropped) and at empty.
    always_ff @(posedge clk) begin
        if (reset)
            occ <= '0;
        else if (rx_done_tick && !rd_uart && (occ != OCC_MAX))
            occ <= occ + 1'b1;
        else if (rd_uart && !rx_done_tick && (occ != '0))
            occ <= occ - 1'b1;
    end

    // Level interrupt, registered from the enables and current flag/FIFO state.
    always_ff @(posedge clk) begin
        if (reset)
            bus.irq <= 1'b0;
        else
            bus.irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & ~tx_full) |
                       (ctrl[2] & (rx_ovr | tx_ovf | rx_tmo));
    end

`ifdef UART_IF_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rx_idle;

    assign rx_idle = ~rx_empty & ~rx_done_tick & ~rd_uart;
    assign tmo_evt = rx_idle & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Idle counter: restarts on any RX activity, holds once the timeout is reached.
    always_ff @(posedge clk) begin
        if (reset || !rx_idle)
            tmo_cnt <= '0;
        else if (!tmo_evt)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_evt = 1'b0;
`endif

    // The occupancy mirror must agree with the uart's own empty flag.
    occ_tracks_fifo: assert property (@(posedge clk) disable iff (reset)
                                      ((occ == '0) == rx_empty));

    // A timeout shorter than two cycles cannot be distinguished from activity.
    timeout_cfg_ok: assert property (@(posedge clk) (TIMEOUT_CYC >= 2));

endmodule

// File: tb/tb_uart_bus_if.sv
// Bench for uart_bus_if: directed steps followed by randomized bus/RX traffic.
// A transaction-level model (queue-based RX FIFO, register map, sticky flags)
// predicts every DUT output after every clock edge.
module tb_uart_bus_if;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_uart, wr_uart;
    logic [7:0]  w_data;
    logic [20:0] dvsr;
    logic [7:0]  r_data;
    logic        tx_full, rx_empty, rx_done_tick;
    logic [7:0]  rx_byte;

    uart_bus_if_if bus();

    uart_bus_if #(.FIFO_W(2), .DVSR_RST(21'd324), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .dvsr(dvsr),
        .r_data(r_data), .tx_full(tx_full), .rx_empty(rx_empty),
        .rx_done_tick(rx_done_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  m_ctrl, m_st0, m_st1, m_rd_data, m_w_data;
    logic [20:0] m_dvsr;
    bit          m_ovr, m_ovf, m_tmo, m_irq, m_rd_uart, m_wr_uart;
    int          idle_run;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from pre-edge inputs, step, compare, then move the RX FIFO stub.
    task automatic tick();
        bit         rd, wr, empty, pop, push, idle, ovr_e, ovf_e, tmo_e, clr, nx_irq;
        logic [7:0] status, sel_byte;
        logic [1:0] dsel;
        empty = (rxq.size() == 0);
        rd    = bus.cs & bus.rd_en & ~bus.wr_en;
        wr    = bus.cs & bus.wr_en;
        pop   = m_rd_uart;
        push  = rx_done_tick;
        if (reset) begin
            m_ctrl = 8'h00; m_st0 = 8'h00; m_st1 = 8'h00; m_rd_data = 8'h00;
            m_w_data = 8'h00; m_dvsr = 21'd324; m_ovr = 0; m_ovf = 0; m_tmo = 0;
            m_irq = 0; m_rd_uart = 0; m_wr_uart = 0; idle_run = 0;
        end else begin
            status = {m_irq, 2'b00, m_tmo, m_ovf, m_ovr, tx_full, ~empty};
            nx_irq = (m_ctrl[0] & ~empty) | (m_ctrl[1] & ~tx_full) |
                     (m_ctrl[2] & (m_ovr | m_ovf | m_tmo));
            dsel     = m_ctrl[5:4];
            sel_byte = (dsel == 2'd3) ? 8'h00 : 8'(m_dvsr >> (8 * int'(dsel)));
            if (rd) begin
                case (bus.addr)
                    2'd0:    m_rd_data = empty ? 8'h00 : rxq[0];
                    2'd1:    m_rd_data = status;
                    2'd2:    m_rd_data = m_ctrl;
                    default: m_rd_data = sel_byte;
                endcase
            end
            m_rd_uart = rd && (bus.addr == 2'd0) && !empty;
            m_wr_uart = wr && (bus.addr == 2'd0) && !tx_full;
            if (m_wr_uart) m_w_data = bus.wr_data;
            if (wr && bus.addr == 2'd2) m_ctrl = bus.wr_data & 8'h37;
            if (wr && bus.addr == 2'd3) begin
                if (dsel == 2'd0) m_st0 = bus.wr_data;
                else if (dsel == 2'd1) m_st1 = bus.wr_data;
                else if (dsel == 2'd2) m_dvsr = {bus.wr_data[4:0], m_st1, m_st0};
            end
            ovr_e = push && (rxq.size() == DEPTH);
            ovf_e = wr && (bus.addr == 2'd0) && tx_full;
            idle  = !empty && !push && !pop;
`ifdef UART_IF_RX_TIMEOUT_EN
            tmo_e    = idle && (idle_run >= TMO - 1);
`else
            tmo_e    = 0;
`endif
            idle_run = idle ? idle_run + 1 : 0;
            clr   = rd && (bus.addr == 2'd1);
            m_ovr = (m_ovr && !clr) || ovr_e;
            m_ovf = (m_ovf && !clr) || ovf_e;
            m_tmo = (m_tmo && !clr) || tmo_e;
            m_irq = nx_irq;
        end
        @(posedge clk);
        #1;
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
        chk("irq",     32'(bus.irq),     32'(m_irq));
        chk("rd_uart", 32'(rd_uart),     32'(m_rd_uart));
        chk("wr_uart", 32'(wr_uart),     32'(m_wr_uart));
        chk("w_data",  32'(w_data),      32'(m_w_data));
        chk("dvsr",    32'(dvsr),        32'(m_dvsr));
        if (reset) rxq.delete();
        else begin
            if (pop && rxq.size() > 0) void'(rxq.pop_front());
            if (push && rxq.size() < DEPTH) rxq.push_back(rx_byte);
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'hEE : rxq[0];
    endtask

    task automatic bus_op(input bit is_wr, input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1; bus.addr = a; bus.rd_en = !is_wr; bus.wr_en = is_wr; bus.wr_data = d;
        tick();
        bus.cs = 0; bus.rd_en = 0; bus.wr_en = 0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_byte = b; rx_done_tick = 1;
        tick();
        rx_done_tick = 0;
    endtask

    initial begin
        bus.cs = 0; bus.rd_en = 0; bus.wr_en = 0; bus.addr = 0; bus.wr_data = 0;
        tx_full = 0; rx_done_tick = 0; rx_byte = 0; rx_empty = 1; r_data = 8'hEE;
        reset = 1; tick(); tick(); reset = 0;
        chk("rst_dvsr", 32'(dvsr), 32'd324);
        chk("rst_irq", 32'(bus.irq), 32'd0);

        // Reset-state register reads
        bus_op(0, 2'd1, 8'h00); chk("status_rst", 32'(bus.rd_data), 32'h00);
        bus_op(0, 2'd3, 8'h00); chk("dvsr_b0", 32'(bus.rd_data), 32'h44);
        bus_op(1, 2'd2, 8'h10); bus_op(0, 2'd3, 8'h00); chk("dvsr_b1", 32'(bus.rd_data), 32'h01);
        bus_op(1, 2'd2, 8'h20); bus_op(0, 2'd3, 8'h00); chk("dvsr_b2", 32'(bus.rd_data), 32'h00);
        bus_op(1, 2'd2, 8'hF0); bus_op(0, 2'd2, 8'h00); chk("ctrl_mask", 32'(bus.rd_data), 32'h30);

        // Divisor staging and atomic commit
        bus_op(1, 2'd2, 8'h00); bus_op(1, 2'd3, 8'h35);
        bus_op(1, 2'd2, 8'h10); bus_op(1, 2'd3, 8'h00);
        bus_op(1, 2'd2, 8'h20); chk("dvsr_hold", 32'(dvsr), 32'd324);
        bus_op(1, 2'd3, 8'hFF); chk("dvsr_commit", 32'(dvsr), 32'h1F0035);
        bus_op(0, 2'd3, 8'h00); chk("dvsr_rb2", 32'(bus.rd_data), 32'h1F);

        // TX push and overflow
        bus_op(1, 2'd2, 8'h00);
        bus_op(1, 2'd0, 8'hA5); chk("push", 32'(wr_uart), 32'd1); chk("push_data", 32'(w_data), 32'hA5);
        tick(); chk("push_pulse", 32'(wr_uart), 32'd0);
        tx_full = 1;
        bus_op(1, 2'd0, 8'h5A); chk("no_push", 32'(wr_uart), 32'd0);
        bus_op(0, 2'd1, 8'h00); chk("status_ovf", 32'(bus.rd_data), 32'h0A);
        bus_op(0, 2'd1, 8'h00); chk("status_clr", 32'(bus.rd_data), 32'h02);
        tx_full = 0;

        // RX overrun with ERR_IE
        bus_op(1, 2'd2, 8'h04);
        for (int i = 0; i < 5; i++) rx_push(8'(8'h10 + i));
        chk("irq_lag", 32'(bus.irq), 32'd0);
        tick(); chk("irq_ovr", 32'(bus.irq), 32'd1);
        bus_op(0, 2'd1, 8'h00); chk("status_ovr", 32'(bus.rd_data), 32'h85);
        for (int i = 0; i < 4; i++) begin
            bus_op(0, 2'd0, 8'h00);
            chk("drain", 32'(bus.rd_data), 32'(8'h10 + i));
            chk("drain_pop", 32'(rd_uart), 32'd1);
            tick();
        end
        bus_op(1, 2'd2, 8'h00);

        // Read coinciding with a new RX byte
        rx_push(8'h3C);
        rx_byte = 8'h77; rx_done_tick = 1;
        bus_op(0, 2'd0, 8'h00);
        rx_done_tick = 0;
        chk("coinc_data", 32'(bus.rd_data), 32'h3C); chk("coinc_pop", 32'(rd_uart), 32'd1);
        tick();
        bus_op(0, 2'd1, 8'h00); chk("coinc_status", 32'(bus.rd_data), 32'h01);
        bus_op(0, 2'd0, 8'h00); chk("coinc_next", 32'(bus.rd_data), 32'h77);
        tick();
        bus_op(0, 2'd1, 8'h00); chk("coinc_empty", 32'(bus.rd_data), 32'h00);

        // RX idle timeout
        rx_push(8'h5A);
        for (int i = 0; i < TMO + 2; i++) tick();
        bus_op(0, 2'd1, 8'h00);
`ifdef UART_IF_RX_TIMEOUT_EN
        chk("tmo_set", 32'(bus.rd_data[4]), 32'd1);
`else
        chk("tmo_absent", 32'(bus.rd_data[4]), 32'd0);
`endif
        bus_op(0, 2'd0, 8'h00); chk("tmo_byte", 32'(bus.rd_data), 32'h5A);
        tick();
        bus_op(0, 2'd1, 8'h00);
        bus_op(0, 2'd1, 8'h00); chk("tmo_cleared", 32'(bus.rd_data), 32'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.cs       = ($urandom_range(0, 3) != 0);
            bus.rd_en    = ($urandom_range(0, 2) == 0);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.addr     = 2'($urandom_range(0, 3));
            bus.wr_data  = 8'($urandom_range(0, 255));
            rx_byte      = 8'($urandom_range(0, 255));
            rx_done_tick = ($urandom_range(0, 3) == 0);
            tx_full      = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Reset in the middle of a push
        bus.cs = 1; bus.wr_en = 1; bus.rd_en = 0; bus.addr = 2'd0; bus.wr_data = 8'h66;
        tx_full = 0; rx_done_tick = 0; reset = 1;
        tick();
        chk("rst_squash", 32'(wr_uart), 32'd0);
        chk("rst_dvsr2", 32'(dvsr), 32'd324);
        reset = 0; bus.cs = 0; bus.wr_en = 0;
        bus_op(0, 2'd1, 8'h00); chk("status_rst2", 32'(bus.rd_data), 32'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
